// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads have strict priority over
// camera writes, which are buffered in a small FIFO tagged with their address.
module fb_port_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 12,
  parameter int FRAME_PIX = 307200,
  parameter int WF_DEPTH  = 4
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic                        iRd_Req,
  input  logic                        iRd_Frame_Start,
  output logic [DATA_W-1:0]           oRd_Data,
  output logic                        oRd_Valid,
  input  logic                        iWr_Valid,
  input  logic [DATA_W-1:0]           iWr_Data,
  output logic                        oWr_Ready,
  input  logic                        iWr_Frame_Start,
  output logic                        oMem_En,
  output logic                        oMem_We,
  output logic [ADDR_W-1:0]           oMem_Addr,
  output logic [DATA_W-1:0]           oMem_WData,
  input  logic [DATA_W-1:0]           iMem_RData,
  output logic [$clog2(WF_DEPTH):0]   oWf_Level,
  output logic                        oWr_Overflow
);

  localparam int PW = $clog2(WF_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {WF_EMPTY, WF_PARTIAL, WF_FULL} wf_state_t;

  wf_state_t         wf_state_q, wf_state_d;
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_pend_q, rd_valid_q, ovf_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [ADDR_W-1:0] fifo_addr_q [WF_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [WF_DEPTH];

  logic              wr_ready, push, pop;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  // Ready comes from registered state only, so a pop never reaches oWr_Ready.
  assign wr_ready = (wf_state_q != WF_FULL);
  assign push     = iWr_Valid & wr_ready;
  assign pop      = ~iRd_Req & (wf_state_q != WF_EMPTY);
  assign rd_addr  = iRd_Frame_Start ? '0 : rd_cnt_q;
  assign wr_addr  = iWr_Frame_Start ? '0 : wr_cnt_q;

  always_comb begin
    wf_state_d  = wf_state_q;
    level_d     = level_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (iRd_Req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr;
      rd_cnt_d   = next_addr(rd_addr);
    end else begin
      rd_cnt_d = rd_addr;
      if (pop) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = fifo_addr_q[rptr_q];
        mem_wdata_d = fifo_data_q[rptr_q];
        rptr_d      = rptr_q + PW'(1);
      end
    end

    if (push) begin
      wptr_d   = wptr_q + PW'(1);
      wr_cnt_d = next_addr(wr_addr);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (level_d == '0)                wf_state_d = WF_EMPTY;
    else if (level_d == LW'(WF_DEPTH)) wf_state_d = WF_FULL;
    else                              wf_state_d = WF_PARTIAL;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      wf_state_q  <= WF_EMPTY;
      level_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wf_state_q  <= wf_state_d;
      level_q     <= level_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= mem_en_q & ~mem_we_q;
      rd_valid_q  <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= iMem_RData;
      ovf_q       <= ovf_q | (iWr_Valid & ~wr_ready);
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr;
      fifo_data_q[wptr_q] <= iWr_Data;
    end
  end

  assign oRd_Data     = rd_data_q;
  assign oRd_Valid    = rd_valid_q;
  assign oWr_Ready    = wr_ready;
  assign oMem_En      = mem_en_q;
  assign oMem_We      = mem_we_q;
  assign oMem_Addr    = mem_addr_q;
  assign oMem_WData   = mem_wdata_q;
  assign oWf_Level    = level_q;
  assign oWr_Overflow = ovf_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based transaction model and a memory model.
module tb_fb_port_arbiter;

  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 12;
  localparam int FRAME_PIX = 8;
  localparam int WF_DEPTH  = 4;
  localparam int LW        = $clog2(WF_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n, rd_req, rd_fs, wr_valid, wr_fs;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data, mem_wdata, mem_rdata;
  logic              rd_valid, wr_ready, mem_en, mem_we, wr_ovf;
  logic [ADDR_W-1:0] mem_addr;
  logic [LW-1:0]     wf_level;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIX(FRAME_PIX), .WF_DEPTH(WF_DEPTH)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .iRd_Req(rd_req), .iRd_Frame_Start(rd_fs),
    .oRd_Data(rd_data), .oRd_Valid(rd_valid),
    .iWr_Valid(wr_valid), .iWr_Data(wr_data), .oWr_Ready(wr_ready),
    .iWr_Frame_Start(wr_fs),
    .oMem_En(mem_en), .oMem_We(mem_we), .oMem_Addr(mem_addr),
    .oMem_WData(mem_wdata), .iMem_RData(mem_rdata),
    .oWf_Level(wf_level), .oWr_Overflow(wr_ovf)
  );

  // Synchronous single-port RAM serving the DUT, preloaded with mem[a] = a.
  logic [DATA_W-1:0] ram [FRAME_PIX];
  initial for (int i = 0; i < FRAME_PIX; i++) ram[i] = DATA_W'(i);
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr) % FRAME_PIX] <= mem_wdata;
      else        mem_rdata <= ram[int'(mem_addr) % FRAME_PIX];
    end

  // Reference model state
  typedef struct { int addr; int data; } wr_t;
  typedef struct { int due;  int data; } rd_t;
  wr_t fifo_m [$];
  rd_t rdq_m  [$];
  int  model_mem [FRAME_PIX];
  int  rd_cnt_m, wr_cnt_m, addr_m, wdata_m, rdata_m, cyc_n;
  bit  en_m, we_m, ovf_m;
  int  n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, rd, rfs, wv, input int wd, input bit wfs);
    bit room;
    int a;
    wr_t h;
    cyc_n++;
    if (!rst) begin
      fifo_m.delete(); rdq_m.delete();
      rd_cnt_m = 0; wr_cnt_m = 0; addr_m = 0; wdata_m = 0; rdata_m = 0;
      en_m = 0; we_m = 0; ovf_m = 0;
      return;
    end
    room = fifo_m.size() < WF_DEPTH;
    en_m = 0; we_m = 0;
    if (rd) begin
      a = rfs ? 0 : rd_cnt_m;
      rd_cnt_m = (a + 1) % FRAME_PIX;
      en_m = 1; addr_m = a;
      rdq_m.push_back('{due: cyc_n + 2, data: model_mem[a]});
    end else begin
      if (rfs) rd_cnt_m = 0;
      if (fifo_m.size() > 0) begin
        h = fifo_m.pop_front();
        en_m = 1; we_m = 1; addr_m = h.addr; wdata_m = h.data;
        model_mem[h.addr] = h.data;
      end
    end
    if (wv) begin
      if (room) begin
        a = wfs ? 0 : wr_cnt_m;
        wr_cnt_m = (a + 1) % FRAME_PIX;
        fifo_m.push_back('{addr: a, data: wd});
      end else ovf_m = 1;
    end
  endtask

  task automatic check_all();
    bit exp_v;
    chk("mem_en",    32'(mem_en),    32'(en_m));
    chk("mem_we",    32'(mem_we),    32'(we_m));
    chk("mem_addr",  32'(mem_addr),  32'(addr_m));
    chk("mem_wdata", 32'(mem_wdata), 32'(wdata_m));
    chk("wf_level",  32'(wf_level),  32'(fifo_m.size()));
    chk("wr_ready",  32'(wr_ready),  32'(fifo_m.size() < WF_DEPTH));
    chk("overflow",  32'(wr_ovf),    32'(ovf_m));
    exp_v = (rdq_m.size() > 0) && (rdq_m[0].due == cyc_n);
    if (exp_v) rdata_m = rdq_m.pop_front().data;
    chk("rd_valid",  32'(rd_valid),  32'(exp_v));
    chk("rd_data",   32'(rd_data),   32'(rdata_m));
  endtask

  task automatic step(input bit rst, rd, rfs, wv, input int wd, input bit wfs);
    rst_n = rst; rd_req = rd; rd_fs = rfs; wr_valid = wv;
    wr_data = DATA_W'(wd); wr_fs = wfs;
    @(posedge clk);
    model_step(rst, rd, rfs, wv, wd, wfs);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic reset(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < FRAME_PIX; i++) model_mem[i] = i;
    cyc_n = 0;
    reset(3);
    idle(1);

    // Four reads from frame start: data 0..3 three cycles later
    step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    idle(5);

    // Three camera pixels, first one starting a frame
    step(1, 0, 0, 1, 'hA01, 1);
    step(1, 0, 0, 1, 'hA02, 0);
    step(1, 0, 0, 1, 'hA03, 0);
    idle(4);

    // Contention: reads hold the port while six pixels are offered
    for (int i = 0; i < 10; i++) step(1, 1, i == 0, i < 6, 'hB00 + i, i == 0);
    idle(7);

    // Read address wrap from a clean reset
    reset(1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
    idle(4);

    // Push and pop together at level 2
    step(1, 1, 0, 1, 'hC01, 1);
    step(1, 1, 0, 1, 'hC02, 0);
    step(1, 0, 0, 1, 'hC03, 0);
    idle(5);

    // Reset with queued writes and reads in flight
    step(1, 1, 0, 1, 'hD01, 0);
    step(1, 1, 0, 1, 'hD02, 0);
    step(1, 1, 0, 1, 'hD03, 0);
    reset(1);
    idle(6);

    // Random traffic with phases of differing read pressure
    for (int p = 0; p < 6; p++) begin
      int rd_pct = 20 + p * 15;
      for (int i = 0; i < 500; i++)
        step($urandom_range(199) != 0,
             $urandom_range(99) < rd_pct,
             $urandom_range(99) < 5,
             $urandom_range(99) < 55,
             int'($urandom_range(4095)),
             $urandom_range(99) < 5);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 19, frame-buffer address width.
REQ-002 Parameter DATA_W, 12, pixel width {B[3:0],G[3:0],R[3:0]}.
REQ-003 Parameter FRAME_PIX, 307200, pixels per frame; addresses wrap at FRAME_PIX-1.
REQ-004 Parameter WF_DEPTH, 4, write FIFO depth (power of 2, >=2).
REQ-005 iVGA_CLK  in  1  sole clock; all logic rising-edge.
REQ-006 iRST_n  in  1  synchronous active-low reset, sampled on iVGA_CLK.
REQ-007 iRd_Req  in  1  display pixel request (one pixel per cycle), driven from VGA controller oRequest.
REQ-008 iRd_Frame_Start  in  1  one-cycle pulse; restarts read address at 0.
REQ-009 oRd_Data  out  DATA_W  pixel returned to display.
REQ-010 oRd_Valid  out  1  oRd_Data qualifier.
REQ-011 iWr_Valid  in  1  camera pixel offered.
REQ-012 iWr_Data  in  DATA_W  camera pixel.
REQ-013 oWr_Ready  out  1  camera pixel accepted when iWr_Valid&oWr_Ready.
REQ-014 iWr_Frame_Start  in  1  qualifies the accepted pixel as pixel 0 of a new frame.
REQ-015 oMem_En  out  1  memory port enable, registered.
REQ-016 oMem_We  out  1  memory write enable, registered.
REQ-017 oMem_Addr  out  ADDR_W  memory address, registered.
REQ-018 oMem_WData  out  DATA_W  memory write data, registered.
REQ-019 iMem_RData  in  DATA_W  read data, valid exactly 1 cycle after oMem_En&!oMem_We.
REQ-020 oWf_Level  out  log2(WF_DEPTH)+1  write FIFO occupancy.
REQ-021 oWr_Overflow  out  1  sticky: camera pixel offered while oWr_Ready=0.

Function
REQ-022 Single memory port SHALL serve at most one access per cycle: one read, one write, or idle.
REQ-023 Grant SHALL be strict read priority: iRd_Req=1 -> read grant; else FIFO non-empty -> write grant; else idle.
REQ-024 Read path SHALL be fixed latency 3: iRd_Req at cycle n -> oMem_En=1,oMem_We=0 at n+1 -> iMem_RData at n+2 -> oRd_Data registered, oRd_Valid=1 at n+3.
REQ-025 Read address counter SHALL increment by 1 per granted read, wrapping FRAME_PIX-1 -> 0.
REQ-026 iRd_Frame_Start=1 SHALL set read address to 0; if iRd_Req=1 same cycle, that read uses address 0 and counter becomes 1.
REQ-027 Write address SHALL be assigned at FIFO push and stored with data; counter increments per push, wraps FRAME_PIX-1 -> 0.
REQ-028 Push with iWr_Frame_Start=1 SHALL store address 0 and set counter to 1.
REQ-029 oWr_Ready SHALL be 1 iff FIFO not full (registered level, no combinational path from pop).
REQ-030 Push and pop same cycle SHALL leave oWf_Level unchanged; push when full is impossible (ready low).
REQ-031 Write grant SHALL pop FIFO head and drive oMem_En=1,oMem_We=1,oMem_Addr/oMem_WData=head next cycle.
REQ-032 Idle cycle SHALL drive oMem_En=0,oMem_We=0; oMem_Addr/oMem_WData hold last value.
REQ-033 iWr_Valid&!oWr_Ready SHALL drop the pixel, not advance write address, and set oWr_Overflow.
REQ-034 FIFO order SHALL be strictly first-in-first-out; no write SHALL be lost except per REQ-033.
REQ-035 Write pipeline state SHALL be FSM: EMPTY (level 0), PARTIAL, FULL (level WF_DEPTH); transitions by push/pop per REQ-030.

Reset
REQ-036 iRST_n=0 at a clock edge SHALL clear: both address counters, FIFO (level 0, EMPTY), read pipeline, oRd_Valid, oRd_Data, oMem_En, oMem_We, oMem_Addr, oMem_WData, oWr_Overflow to 0; oWr_Ready=1 the cycle after release.
REQ-037 Reset mid-operation SHALL discard in-flight reads (no oRd_Valid after reset) and queued writes.
REQ-038 oWr_Overflow SHALL clear only by reset.

Verification
REQ-039 Reads only: iRd_Frame_Start+iRd_Req for 4 cycles, memory returns addr -> oRd_Valid cycles 3..6, oRd_Data=0,1,2,3.
REQ-040 Writes only: 3 pixels 0xA01,0xA02,0xA03 with frame start on first -> writes to addr 0,1,2 in order, level returns 0.
REQ-041 Contention: iRd_Req held 10 cycles, 6 pixels offered -> 4 accepted, ready low, 2 dropped, oWr_Overflow=1, no writes until iRd_Req=0, then 4 writes addr 0..3.
REQ-042 Wrap: FRAME_PIX=8, 10 reads without frame start -> addresses 0..7,0,1.
REQ-043 Simultaneous push and pop at level 2 -> level stays 2, ready stays 1.
REQ-044 Reset asserted with 3 queued writes and 2 reads in flight -> no oMem_We, no oRd_Valid afterwards; level 0; overflow 0.
